trig_sched: RTL and testbench

- Frame scheduler and configuration controller for the trigger-driven line timing generator.
- Generates the pixel count-enable (ena) from a programmable clock prescaler.
- Issues one-clock trig pulses at a programmable frame period, for N frames or continuously.
- Double-buffers Thsync/Thlen, so configuration changes take effect only on frame boundaries.

---
 rtl/trig_sched_pkg.sv | 13 +
 rtl/trig_sched_if.sv | 44 ++++
 rtl/trig_sched_prediv.sv | 26 ++
 rtl/trig_sched.sv | 127 ++++++++++++
 tb/tb_trig_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/trig_sched_pkg.sv
// trig_sched_pkg: shared widths and FSM state encoding for the frame scheduler.
package trig_sched_pkg;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_PER_W = 24;
    localparam int DEF_FRM_W = 16;
    localparam int THSYNC_W  = 8;
    localparam int THLEN_W   = 16;
    typedef enum logic [2:0] {
        IDLE_S = 3'b001,
        ARM_S  = 3'b010,
        RUN_S  = 3'b100
    } state_t;
endpackage

// File: rtl/trig_sched_if.sv
// trig_sched_if: host config/control and timing-generator signals of trig_sched.
// TRIG_SCHED_EXT_SYNC_EN adds ext_trig/ext_lost.
interface trig_sched_if
    import trig_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int PER_W = DEF_PER_W,
    parameter int FRM_W = DEF_FRM_W
);
    logic                cfg_we;
    logic [THSYNC_W-1:0] cfg_thsync;
    logic [THLEN_W-1:0]  cfg_thlen;
    logic [DIV_W-1:0]    cfg_div;
    logic [PER_W-1:0]    cfg_period;
    logic [FRM_W-1:0]    cfg_nframes;
    logic                start;
    logic                stop;
    logic                ena;
    logic                trig;
    logic [THSYNC_W-1:0] thsync;
    logic [THLEN_W-1:0]  thlen;
    logic                busy;
    logic                cfg_pend;
    logic [FRM_W-1:0]    frame_cnt;
    logic                frame_strb;
`ifdef TRIG_SCHED_EXT_SYNC_EN
    logic                ext_trig;
    logic                ext_lost;
`endif
    modport master (
`ifdef TRIG_SCHED_EXT_SYNC_EN
        output ext_trig, input ext_lost,
`endif
        output cfg_we, cfg_thsync, cfg_thlen, cfg_div, cfg_period, cfg_nframes, start, stop,
        input  ena, trig, thsync, thlen, busy, cfg_pend, frame_cnt, frame_strb
    );
    modport slave (
`ifdef TRIG_SCHED_EXT_SYNC_EN
        input ext_trig, output ext_lost,
`endif
        input  cfg_we, cfg_thsync, cfg_thlen, cfg_div, cfg_period, cfg_nframes, start, stop,
        output ena, trig, thsync, thlen, busy, cfg_pend, frame_cnt, frame_strb
    );
endinterface

// File: rtl/trig_sched_prediv.sv
// trig_sched_prediv: clock prescaler producing a registered ena once every div+1 running cycles.
module trig_sched_prediv #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             ena
);
    logic             act;
    logic [DIV_W-1:0] cnt, nxt;
    // run/div are next-cycle values, so ena lines up with the cycle where cnt==div
    always_comb nxt = (!run || !act || ena) ? '0 : cnt + DIV_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            act <= 1'b0;
            cnt <= '0;
            ena <= 1'b0;
        end else begin
            act <= run;
            cnt <= nxt;
            ena <= run && nxt == div;
        end
    end
endmodule

// File: rtl/trig_sched.sv
// trig_sched: frame trigger scheduler with double-buffered line timing configuration.
// TRIG_SCHED_EXT_SYNC_EN enables external trigger sync with period watchdog.
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int PER_W = DEF_PER_W,
    parameter int FRM_W = DEF_FRM_W
) (
    input logic clk,
    input logic rst,
    trig_sched_if.slave bus
);
    state_t              state, state_n;
    logic [THSYNC_W-1:0] stg_thsync, thsync_a;
    logic [THLEN_W-1:0]  stg_thlen, thlen_a;
    logic [DIV_W-1:0]    stg_div, div_a, div_n;
    logic [PER_W-1:0]    stg_period, period_a, period_n, per_cnt;
    logic [FRM_W-1:0]    stg_nframes, nframes_a, frame_cnt;
    logic stop_pend, cfg_pend, trig, ena, apply, fire, halt, boundary, limit, force_b;
    // a write landing on the apply edge bypasses staging
    assign div_n    = apply ? (bus.cfg_we ? bus.cfg_div : stg_div) : div_a;
    assign period_n = apply ? (bus.cfg_we ? bus.cfg_period : stg_period) : period_a;
    assign limit    = nframes_a != '0 && frame_cnt == nframes_a;
    // holding off while trig is high keeps pulses from touching at period 1, div 0
    assign boundary = ena && !trig && (per_cnt == '0 || force_b);
    always_comb begin
        state_n = state;
        apply   = 1'b0;
        fire    = 1'b0;
        halt    = 1'b0;
        case (state)
            IDLE_S: begin
                apply   = bus.start;
                state_n = bus.start ? ARM_S : IDLE_S;
            end
            ARM_S: begin
                fire    = ena;
                state_n = ena ? RUN_S : ARM_S;
            end
            RUN_S: begin
                halt    = boundary && (stop_pend || limit);
                fire    = boundary && !(stop_pend || limit);
                apply   = fire;
                state_n = halt ? IDLE_S : RUN_S;
            end
            default: state_n = IDLE_S;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE_S;
            stg_thsync  <= '0;
            stg_thlen   <= '0;
            stg_div     <= '0;
            stg_period  <= '0;
            stg_nframes <= '0;
            thsync_a    <= '0;
            thlen_a     <= '0;
            div_a       <= '0;
            period_a    <= '0;
            nframes_a   <= '0;
            cfg_pend    <= 1'b0;
            trig        <= 1'b0;
            stop_pend   <= 1'b0;
            frame_cnt   <= '0;
            per_cnt     <= '0;
        end else begin
            state <= state_n;
            if (bus.cfg_we) begin
                stg_thsync  <= bus.cfg_thsync;
                stg_thlen   <= bus.cfg_thlen;
                stg_div     <= bus.cfg_div;
                stg_period  <= bus.cfg_period;
                stg_nframes <= bus.cfg_nframes;
            end
            if (apply) begin
                thsync_a  <= bus.cfg_we ? bus.cfg_thsync : stg_thsync;
                thlen_a   <= bus.cfg_we ? bus.cfg_thlen : stg_thlen;
                nframes_a <= bus.cfg_we ? bus.cfg_nframes : stg_nframes;
            end
            div_a     <= div_n;
            period_a  <= period_n;
            cfg_pend  <= !apply && (bus.cfg_we || cfg_pend);
            trig      <= fire;
            stop_pend <= state != IDLE_S && !halt && (stop_pend || bus.stop);
            frame_cnt <= (state == IDLE_S && bus.start) ? '0 : fire ? frame_cnt + FRM_W'(1) : frame_cnt;
            per_cnt   <= state_n == IDLE_S ? '0 :
                         fire ? ((period_n == '0) ? '0 : period_n - PER_W'(1)) :
                         (state == RUN_S && ena && per_cnt != '0) ? per_cnt - PER_W'(1) : per_cnt;
        end
    end
`ifdef TRIG_SCHED_EXT_SYNC_EN
    logic [2:0] ext_sync;
    logic       ext_pend, ext_lost;
    assign force_b = ext_pend;
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sync <= '0;
            ext_pend <= 1'b0;
            ext_lost <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[1:0], bus.ext_trig};
            ext_pend <= state == RUN_S && state_n == RUN_S && ((ext_sync[1] && !ext_sync[2]) || (ext_pend && !fire));
            ext_lost <= !(state == IDLE_S && bus.start) && (ext_lost || (state == RUN_S && fire && !ext_pend));
        end
    end
    assign bus.ext_lost = ext_lost;
`else
    assign force_b = 1'b0;
`endif
    trig_sched_prediv #(.DIV_W(DIV_W)) u_prediv (
        .clk(clk),
        .rst(rst),
        .run(state_n != IDLE_S),
        .div(div_n),
        .ena(ena)
    );
    assign bus.ena        = ena;
    assign bus.trig       = trig;
    assign bus.frame_strb = trig;
    assign bus.thsync     = thsync_a;
    assign bus.thlen      = thlen_a;
    assign bus.busy       = state != IDLE_S;
    assign bus.cfg_pend   = cfg_pend;
    assign bus.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_trig_sched.sv
// tb_trig_sched: directed self-checking bench for trig_sched.
module tb_trig_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_trig = 1'b0;
    logic dbl = 1'b0;
    trig_sched_if bus ();
    trig_sched dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prev_trig && bus.trig) dbl <= 1'b1;
        prev_trig <= bus.trig;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic cfg(input logic [7:0] hs, input logic [15:0] hl, input logic [7:0] dv,
                       input logic [23:0] pr, input logic [15:0] nf);
        bus.cfg_thsync  = hs;
        bus.cfg_thlen   = hl;
        bus.cfg_div     = dv;
        bus.cfg_period  = pr;
        bus.cfg_nframes = nf;
        bus.cfg_we      = 1'b1;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask
    task automatic pulse_start(input logic with_stop);
        bus.start = 1'b1;
        bus.stop  = with_stop;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask
    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask
    task automatic wait_trig(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim && t < 0; i++) begin
            @(negedge clk);
            if (bus.trig) t = cyc;
        end
        check("trig_seen", t >= 0, 1);
    endtask
    task automatic count(input int n, output int trigs, output int enas);
        trigs = 0;
        enas  = 0;
        repeat (n) begin
            @(negedge clk);
            trigs += int'(bus.trig);
            enas  += int'(bus.ena);
        end
    endtask
    initial begin
        int c, t, t2, t3, tr, en;
        bus.cfg_we = 1'b0; bus.cfg_thsync = '0; bus.cfg_thlen = '0; bus.cfg_div = '0;
        bus.cfg_period = '0; bus.cfg_nframes = '0; bus.start = 1'b0; bus.stop = 1'b0;
`ifdef TRIG_SCHED_EXT_SYNC_EN
        bus.ext_trig = 1'b0;
`endif
        step(3);
        check("rst_busy", bus.busy, 0);
        check("rst_ena", bus.ena, 0);
        check("rst_trig", bus.trig, 0);
        check("rst_fcnt", bus.frame_cnt, 0);
        check("rst_thlen", bus.thlen, 0);
        rst = 1'b0;
        step(1);
        // three frames, period 10, no prescale
        cfg(5, 800, 0, 10, 3);
        check("t1_pend_set", bus.cfg_pend, 1);
        check("t1_thlen_staged", bus.thlen, 0);
        c = cyc;
        pulse_start(1'b0);
        check("t1_pend_clr", bus.cfg_pend, 0);
        check("t1_thlen", bus.thlen, 800);
        check("t1_thsync", bus.thsync, 5);
        wait_trig(20, t);
        check("t1_latency", t - c, 2);
        check("t1_strb", bus.frame_strb, 1);
        check("t1_fcnt1", bus.frame_cnt, 1);
        wait_trig(20, t2);
        check("t1_space2", t2 - t, 10);
        wait_trig(20, t3);
        check("t1_space3", t3 - t2, 10);
        count(9, tr, en);
        check("t1_no_4th", tr, 0);
        check("t1_busy_before", bus.busy, 1);
        step(1);
        check("t1_busy_end", bus.busy, 0);
        check("t1_trig_end", bus.trig, 0);
        check("t1_fcnt3", bus.frame_cnt, 3);
        // prescaler div 3, period 5, continuous, then stop
        cfg(5, 800, 3, 5, 0);
        c = cyc;
        pulse_start(1'b0);
        wait_trig(30, t);
        check("t2_latency", t - c, 5);
        count(20, tr, en);
        check("t2_trig20", tr, 1);
        check("t2_ena_duty", en, 5);
        check("t2_trig_at20", bus.trig, 1);
        step(7);
        pulse_stop();
        count(11, tr, en);
        check("t2_no_trig_stop", tr, 0);
        check("t2_busy_pre", bus.busy, 1);
        step(1);
        check("t2_busy_stop", bus.busy, 0);
        check("t2_trig_stop", bus.trig, 0);
        check("t2_ena_idle", bus.ena, 0);
        // mid-frame config change applied at next boundary
        cfg(5, 800, 0, 10, 0);
        pulse_start(1'b0);
        wait_trig(10, t);
        step(3);
        cfg(5, 1000, 0, 10, 0);
        check("t3_pend", bus.cfg_pend, 1);
        check("t3_thlen_old", bus.thlen, 800);
        wait_trig(20, t2);
        check("t3_space", t2 - t, 10);
        check("t3_thlen_new", bus.thlen, 1000);
        check("t3_pend_clr", bus.cfg_pend, 0);
        // write coincident with the boundary
        step(9);
        cfg(5, 1200, 0, 10, 0);
        check("t4_trig", bus.trig, 1);
        check("t4_thlen", bus.thlen, 1200);
        check("t4_pend", bus.cfg_pend, 0);
        pulse_stop();
        step(9);
        check("t4_idle", bus.busy, 0);
        // period 0 as 1, start+stop in IDLE, start while busy
        cfg(9, 700, 1, 0, 2);
        c = cyc;
        pulse_start(1'b1);
        wait_trig(10, t);
        check("t5_latency", t - c, 3);
        pulse_start(1'b0);
        wait_trig(10, t2);
        check("t5_space", t2 - t, 2);
        step(1);
        check("t5_busy_pre", bus.busy, 1);
        step(1);
        check("t5_busy_end", bus.busy, 0);
        check("t5_fcnt", bus.frame_cnt, 2);
        // reset in RUN with a pending write
        cfg(7, 900, 0, 10, 0);
        pulse_start(1'b0);
        wait_trig(10, t);
        step(3);
        cfg(1, 2, 0, 3, 0);
        rst = 1'b1;
        step(1);
        check("t6_busy", bus.busy, 0);
        check("t6_ena", bus.ena, 0);
        check("t6_pend", bus.cfg_pend, 0);
        check("t6_thsync", bus.thsync, 0);
        check("t6_thlen", bus.thlen, 0);
        check("t6_fcnt", bus.frame_cnt, 0);
        rst = 1'b0;
        count(15, tr, en);
        check("t6_no_trig", tr, 0);
        check("t6_idle", bus.busy, 0);
`ifdef TRIG_SCHED_EXT_SYNC_EN
        begin
            int   hit [4];
            int   nh;
            logic lost_mid;
            nh = 0;
            lost_mid = 1'b1;
            cfg(5, 800, 0, 100, 0);
            pulse_start(1'b0);
            wait_trig(10, t);
            for (int k = 1; k <= 240; k++) begin
                @(negedge clk);
                if (bus.trig && nh < 4) hit[nh++] = k;
                if (k == 134) lost_mid = bus.ext_lost;
                bus.ext_trig = (k >= 10 && k < 15) || (k >= 70 && k < 75) || (k >= 130 && k < 135);
            end
            check("ext_nhits", nh, 4);
            check("ext_hit0", hit[0], 14);
            check("ext_hit1", hit[1], 74);
            check("ext_hit2", hit[2], 134);
            check("ext_hit3", hit[3], 234);
            check("ext_lost_mid", lost_mid, 0);
            check("ext_lost_end", bus.ext_lost, 1);
        end
`endif
        check("no_back2back", dbl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
